uart_rx_byte: RTL and testbench

Serial byte receiver for the 57600-baud programming link. Synchronises the raw `serial_rxd` pin, recovers 8N1 frames with 16x oversampling and majority voting, and presents each byte on a valid/ready handshake to the program loader that writes received code into system RAM. It runs in the 25.125 MHz PLL domain and flags framing errors and overruns.

---
 rtl/uart_rx_byte_pkg.sv | 31 +++
 rtl/uart_rx_byte_baud_tick.sv | 29 ++
 rtl/uart_rx_byte.sv | 147 ++++++++++++++
 tb/tb_uart_rx_byte.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_byte_pkg.sv
// Shared UART receive definitions: default line settings, sample points,
// receiver state encoding and small helpers.
package uart_rx_byte_pkg;

   localparam int DEFAULT_CLK_HZ = 25125000;
   localparam int DEFAULT_BAUD   = 57600;
   localparam int OVERSAMPLE     = 16;

   // Sample-counter values (after the tick increments it) where votes are taken
   localparam logic [3:0] SAMPLE_FIRST   = 4'd7;
   localparam logic [3:0] SAMPLE_MID     = 4'd8;
   localparam logic [3:0] SAMPLE_LAST    = 4'd9;
   localparam logic [3:0] BIT_LAST_COUNT = 4'd15;

   typedef enum logic [2:0] {
      ST_WAIT_HIGH,
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } rx_state_t;

   function automatic int calc_div(input int clk_hz, input int baud);
      return (clk_hz + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
   endfunction

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_byte_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable
// so the first tick lands a fixed distance after the start edge.
module uart_baud_tick #(
   parameter int DIV = 27
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_reg;

   assign tick = (cnt_reg == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else if (clear || tick) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + CW'(1);
      end
   end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 serial byte receiver with 16x oversampling, 3-sample majority vote,
// valid/ready output handshake and framing/overrun pulses.
module uart_rx_byte
   import uart_rx_byte_pkg::*;
#(
   parameter int CLK_HZ = DEFAULT_CLK_HZ,
   parameter int BAUD   = DEFAULT_BAUD,
   parameter int DIV    = calc_div(CLK_HZ, BAUD)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       serial_rxd,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       framing_error,
   output logic       overrun,
   output logic       busy
);

   logic       rxd_meta_reg;
   logic       rxd_s;
   rx_state_t  state_reg;
   logic [3:0] samp_cnt_reg;
   logic [2:0] bit_idx_reg;
   logic [1:0] vote_reg;
   logic [7:0] shift_reg;
   logic [7:0] data_reg;
   logic       valid_reg;
   logic       framing_error_reg;
   logic       overrun_reg;

   logic       start_detect;
   logic       tick;
   logic [3:0] samp_inc;
   logic       vote;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rxd_meta_reg <= 1'b1;
         rxd_s        <= 1'b1;
      end else begin
         rxd_meta_reg <= serial_rxd;
         rxd_s        <= rxd_meta_reg;
      end
   end

   assign start_detect = (state_reg == ST_IDLE) && !rxd_s;
   assign samp_inc     = samp_cnt_reg + 4'd1;
   assign vote         = majority3(vote_reg[0], vote_reg[1], rxd_s);

   uart_baud_tick #(
      .DIV(DIV)
   ) u_baud_tick (
      .clk  (clk),
      .reset(reset),
      .clear(start_detect),
      .tick (tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg         <= ST_WAIT_HIGH;
         samp_cnt_reg      <= 4'd0;
         bit_idx_reg       <= 3'd0;
         vote_reg          <= 2'b11;
         shift_reg         <= 8'h00;
         data_reg          <= 8'h00;
         valid_reg         <= 1'b0;
         framing_error_reg <= 1'b0;
         overrun_reg       <= 1'b0;
      end else begin
         framing_error_reg <= 1'b0;
         overrun_reg       <= 1'b0;
         if (valid_reg && ready) begin
            valid_reg <= 1'b0;
         end

         case (state_reg)
            ST_WAIT_HIGH: begin
               if (rxd_s) begin
                  state_reg <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (!rxd_s) begin
                  state_reg    <= ST_START;
                  samp_cnt_reg <= 4'd0;
                  bit_idx_reg  <= 3'd0;
               end
            end
            default: begin
               if (tick) begin
                  samp_cnt_reg <= samp_inc;
                  if (samp_inc == SAMPLE_FIRST) vote_reg[0] <= rxd_s;
                  if (samp_inc == SAMPLE_MID)   vote_reg[1] <= rxd_s;

                  if (samp_inc == SAMPLE_LAST) begin
                     case (state_reg)
                        ST_START: begin
                           if (vote) state_reg <= ST_IDLE;
                        end
                        ST_DATA: begin
                           shift_reg <= {vote, shift_reg[7:1]};
                        end
                        ST_STOP: begin
                           // Good stop returns to IDLE at the decision so the
                           // next start edge can arrive during the stop bit.
                           if (vote) begin
                              state_reg <= ST_IDLE;
                              if (!valid_reg || ready) begin
                                 data_reg  <= shift_reg;
                                 valid_reg <= 1'b1;
                              end else begin
                                 overrun_reg <= 1'b1;
                              end
                           end else begin
                              framing_error_reg <= 1'b1;
                              state_reg         <= ST_WAIT_HIGH;
                           end
                        end
                        default: ;
                     endcase
                  end

                  if (samp_cnt_reg == BIT_LAST_COUNT) begin
                     if (state_reg == ST_START) begin
                        state_reg <= ST_DATA;
                     end else if (state_reg == ST_DATA) begin
                        if (bit_idx_reg == 3'd7) state_reg <= ST_STOP;
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                     end
                  end
               end
            end
         endcase
      end
   end

   assign data          = data_reg;
   assign valid         = valid_reg;
   assign framing_error = framing_error_reg;
   assign overrun       = overrun_reg;
   assign busy          = (state_reg == ST_START) || (state_reg == ST_DATA) ||
                          (state_reg == ST_STOP);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: frame-level timing model plus literal checks.
`timescale 1ns/1ps
module tb_uart_rx_byte;

   localparam int BIT_CLK   = 432;   // 16 * 27 clocks per bit
   localparam int START_OFS = 3;     // pin fall -> busy visible
   localparam int STOP_OFS  = 4134;  // pin fall -> stop decision results visible
   localparam int GLITCH_OFS = 246;  // pin fall -> rejected start back in IDLE
   localparam int K_GOOD = 0;
   localparam int K_FE   = 1;
   localparam int K_NONE = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       serial_rxd = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       framing_error;
   logic       overrun;
   logic       busy;

   uart_rx_byte #(
      .CLK_HZ(25125000),
      .BAUD  (57600)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .serial_rxd   (serial_rxd),
      .data         (data),
      .valid        (valid),
      .ready        (ready),
      .framing_error(framing_error),
      .overrun      (overrun),
      .busy         (busy)
   );

   always #20 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Frame events: busy window [start, end) and what happens at cycle end.
   int         ev_start[64];
   int         ev_end[64];
   int         ev_kind[64];
   logic [7:0] ev_b[64];
   int         n_ev = 0;

   task automatic add_ev(input int s, input int e, input int k, input logic [7:0] b,
                         output int idx);
      idx = n_ev;
      ev_start[n_ev] = s;
      ev_end[n_ev]   = e;
      ev_kind[n_ev]  = k;
      ev_b[n_ev]     = b;
      n_ev++;
   endtask

   // Observation log for literal checks
   int         valid_pulses = 0;
   int         fe_pulses = 0;
   int         ov_pulses = 0;
   int         last_rise = -1;
   int         last_fall = -1;
   int         last_fe = -1;
   int         last_ov = -1;
   logic [7:0] rx_log[$];

   function automatic int get_rx(input int i);
      if (i < rx_log.size()) return int'(rx_log[i]);
      return -1;
   endfunction

   // Model of the outputs, evaluated 5 ns after every rising edge
   initial begin
      logic       m_valid;
      logic [7:0] m_data;
      logic       old_v;
      logic       exp_busy;
      logic       exp_fe;
      logic       exp_ov;
      logic       prev_valid;
      m_valid = 1'b0;
      m_data = 8'h00;
      prev_valid = 1'b0;
      forever begin
         @(posedge clk);
         #5;
         if (reset) begin
            m_valid = 1'b0;
            m_data = 8'h00;
            chk("rst_valid", valid, 0);
            chk("rst_data", data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_fe", framing_error, 0);
            chk("rst_ov", overrun, 0);
         end else begin
            exp_busy = 1'b0;
            exp_fe = 1'b0;
            exp_ov = 1'b0;
            old_v = m_valid;
            if (old_v && ready) m_valid = 1'b0;
            for (int i = 0; i < n_ev; i++) begin
               if (cyc >= ev_start[i] && cyc < ev_end[i]) exp_busy = 1'b1;
               if (cyc == ev_end[i]) begin
                  if (ev_kind[i] == K_FE) exp_fe = 1'b1;
                  if (ev_kind[i] == K_GOOD) begin
                     if (!old_v || ready) begin
                        m_valid = 1'b1;
                        m_data = ev_b[i];
                     end else begin
                        exp_ov = 1'b1;
                     end
                  end
               end
            end
            chk("valid", valid, m_valid);
            chk("data", data, m_data);
            chk("busy", busy, exp_busy);
            chk("framing_error", framing_error, exp_fe);
            chk("overrun", overrun, exp_ov);
         end
         if (valid && !prev_valid) begin
            valid_pulses++;
            last_rise = cyc;
            rx_log.push_back(data);
         end
         if (!valid && prev_valid) last_fall = cyc;
         prev_valid = valid;
         if (framing_error) begin fe_pulses++; last_fe = cyc; end
         if (overrun) begin ov_pulses++; last_ov = cyc; end
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called on a falling edge; returns on a falling edge with the line idle.
   task automatic send_frame(input logic [7:0] b, input real bit_clk, input logic stop_bit,
                             output int fall);
      logic [9:0] bits;
      int t_prev;
      int t_next;
      int idx;
      fall = cyc;
      add_ev(fall + START_OFS, fall + STOP_OFS, stop_bit ? K_GOOD : K_FE, b, idx);
      bits = {stop_bit, b, 1'b0};
      t_prev = 0;
      for (int k = 0; k < 10; k++) begin
         serial_rxd = bits[k];
         t_next = $rtoi((k + 1) * bit_clk + 0.5);
         wait_clks(t_next - t_prev);
         t_prev = t_next;
      end
      serial_rxd = 1'b1;
   endtask

   initial begin
      int n;
      int n2;
      int idx;
      int p;
      int r;
      int ra;
      int fe0;
      logic [7:0] b77;

      reset = 1'b1;
      serial_rxd = 1'b1;
      ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("init_valid", valid, 0);
      chk("init_data", data, 8'h00);
      chk("init_busy", busy, 0);
      reset = 1'b0;
      wait_clks(10);

      // Single byte, consumer always ready
      send_frame(8'hA5, 432.0, 1'b1, n);
      wait_clks(50);
      chk("a5_latency", last_rise - n, 4134);
      chk("a5_width", last_fall - last_rise, 1);
      chk("a5_data", get_rx(0), 8'hA5);
      chk("a5_errors", fe_pulses + ov_pulses, 0);

      // Back-to-back frames
      p = valid_pulses;
      send_frame(8'h00, 432.0, 1'b1, n);
      send_frame(8'hFF, 432.0, 1'b1, n);
      send_frame(8'h3C, 432.0, 1'b1, n);
      wait_clks(50);
      chk("b2b_count", valid_pulses - p, 3);
      chk("b2b_byte0", get_rx(p), 8'h00);
      chk("b2b_byte1", get_rx(p + 1), 8'hFF);
      chk("b2b_byte2", get_rx(p + 2), 8'h3C);

      // Overrun: consumer stalled across two frames
      ready = 1'b0;
      p = valid_pulses;
      send_frame(8'h55, 432.0, 1'b1, n);
      send_frame(8'h66, 432.0, 1'b1, n2);
      wait_clks(20);
      chk("ovr_count", ov_pulses, 1);
      chk("ovr_cycle", last_ov - n2, 4134);
      chk("ovr_held_data", data, 8'h55);
      chk("ovr_held_valid", valid, 1);
      ready = 1'b1;
      wait_clks(3);
      chk("ovr_accepted", valid, 0);
      chk("ovr_pulses", valid_pulses - p, 1);

      // Framing error on a low stop bit
      p = valid_pulses;
      send_frame(8'h12, 432.0, 1'b0, n);
      wait_clks(50);
      chk("fe_count", fe_pulses, 1);
      chk("fe_cycle", last_fe - n, 4134);
      chk("fe_no_valid", valid_pulses - p, 0);

      // Break: line low for 20 bit-times, then a real byte
      n = cyc;
      serial_rxd = 1'b0;
      add_ev(n + START_OFS, n + STOP_OFS, K_FE, 8'h00, idx);
      wait_clks(20 * BIT_CLK);
      serial_rxd = 1'b1;
      wait_clks(300);
      send_frame(8'h34, 432.0, 1'b1, n);
      wait_clks(50);
      chk("brk_fe_count", fe_pulses, 2);
      chk("brk_rx_count", valid_pulses - p, 1);
      chk("brk_rx_data", get_rx(p), 8'h34);

      // Quarter-bit glitch on an idle line
      p = valid_pulses;
      fe0 = fe_pulses;
      n = cyc;
      serial_rxd = 1'b0;
      add_ev(n + START_OFS, n + GLITCH_OFS, K_NONE, 8'h00, idx);
      wait_clks(108);
      serial_rxd = 1'b1;
      wait_clks(400);
      chk("glitch_busy", busy, 0);
      chk("glitch_no_valid", valid_pulses - p, 0);
      chk("glitch_no_fe", fe_pulses - fe0, 0);

      // Line rate 2% fast, then 2% slow
      send_frame(8'hC3, 423.36, 1'b1, n);
      wait_clks(50);
      send_frame(8'hC3, 440.64, 1'b1, n);
      wait_clks(50);
      chk("skew_count", valid_pulses - p, 2);
      chk("skew_fast_data", get_rx(p), 8'hC3);
      chk("skew_slow_data", get_rx(p + 1), 8'hC3);

      // Reset in the middle of bit 4 of 0x77
      p = valid_pulses;
      b77 = 8'h77;
      n = cyc;
      serial_rxd = 1'b0;
      add_ev(n + START_OFS, n + STOP_OFS, K_NONE, 8'h00, idx);
      wait_clks(BIT_CLK);
      for (int k = 0; k < 4; k++) begin
         serial_rxd = b77[k];
         wait_clks(BIT_CLK);
      end
      serial_rxd = b77[4];
      wait_clks(200);
      reset = 1'b1;
      ra = cyc;
      ev_end[idx] = ra + 1;
      serial_rxd = 1'b0;
      wait_clks(5);
      chk("midrst_valid", valid, 0);
      chk("midrst_data", data, 8'h00);
      chk("midrst_busy", busy, 0);
      wait_clks(BIT_CLK - 5);
      // Line stays low only briefly after release, so the restart is rejected
      reset = 1'b0;
      r = cyc;
      add_ev(r + START_OFS, r + GLITCH_OFS, K_NONE, 8'h00, idx);
      wait_clks(100);
      serial_rxd = 1'b1;
      wait_clks(400);
      send_frame(8'h88, 432.0, 1'b1, n);
      wait_clks(50);
      chk("rst_rx_count", valid_pulses - p, 1);
      chk("rst_rx_data", get_rx(p), 8'h88);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
